// File: rtl/onchip_mem_stream_reader_pkg.sv
// onchip_mem_stream_reader_pkg
//   Shared definitions for the on-chip RAM stream reader: default widths,
//   the controller state encoding and the layout of one skid-FIFO entry.
//   No ports (package).
package onchip_mem_stream_reader_pkg;

    localparam int ADDR_W_DEFAULT     = 17;
    localparam int DATA_W_DEFAULT     = 32;
    localparam int FIFO_DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // One skid-FIFO entry: end-of-pass flag above the RAM word.
    typedef struct packed {
        logic                      last;
        logic [DATA_W_DEFAULT-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/onchip_mem_stream_reader_fifo.sv
// stream_reader_fifo
//   Small synchronous FIFO used as the output skid buffer of the stream
//   reader. Push and pop may happen in the same cycle. A flush empties the
//   FIFO on the next edge and takes priority over push/pop.
// Ports
//   i_clk, i_reset  clock, asynchronous active-high reset
//   i_flush         drop all entries
//   i_push, i_data  write one entry (ignored when full and not popping)
//   i_pop           consume the head entry (ignored when empty)
//   o_data          head entry
//   o_count         number of stored entries (0..DEPTH)
//   o_empty, o_full occupancy flags
module stream_reader_fifo
    import onchip_mem_stream_reader_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int WIDTH = DATA_W_DEFAULT + 1,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count,
    output logic             o_empty,
    output logic             o_full
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == {CW{1'b0}});
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    // Storage, pointers and occupancy; flush wins over push/pop.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else if (i_flush) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/onchip_mem_stream_reader.sv
// onchip_mem_stream_reader
//   Avalon-MM read initiator for port s2 of the dual-port on-chip RAM. Reads
//   i_length consecutive words from i_base_addr (fixed read latency of 1,
//   no waitrequest) and replays them in order on a valid/ready stream with
//   an end-of-pass flag. Reads are only issued while the skid FIFO has room
//   for the word plus the one already in flight, so the FIFO cannot overflow.
//   Build option STREAM_READER_WRAP_EN: the block loops over the buffer
//   forever (circular buffer) until aborted; out_last marks each pass end.
// Ports
//   i_clk, i_reset             clock, asynchronous active-high reset
//   i_start, i_base_addr,
//   i_length                   start pulse and transfer descriptor (IDLE only)
//   i_abort                    terminate the running transfer
//   o_busy, o_done             status; o_done pulses once per transfer
//   o_mem_*                    Avalon-MM read port towards the RAM
//   i_mem_readdata             RAM q output
//   o_out_data, o_out_valid,
//   i_out_ready, o_out_last    output stream
module onchip_mem_stream_reader
    import onchip_mem_stream_reader_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEFAULT,
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W-1:0] i_length,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic              o_mem_chipselect,
    output logic              o_mem_write,
    output logic [3:0]        o_mem_byteenable,
    output logic              o_mem_clken,
    input  logic [DATA_W-1:0] i_mem_readdata,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_out_last
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_remaining;
    logic              r_inflight;
    logic              r_inflight_last;
    logic              r_busy;
    logic              r_done;
`ifdef STREAM_READER_WRAP_EN
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_len;
`endif

    logic [CW-1:0]     w_fifo_count;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic [DATA_W:0]   w_fifo_head;
    logic              w_room;
    logic              w_issue;
    logic              w_issue_last;
    logic              w_abort_hit;
    logic              w_push;
    logic              w_pop;

    // Words already stored plus the word still coming back from the RAM.
    assign w_room       = ((CW+1)'(w_fifo_count) + (CW+1)'(r_inflight) < (CW+1)'(FIFO_DEPTH))
                          && !w_fifo_full;
    assign w_abort_hit  = i_abort && ((r_state == READ) || (r_state == DRAIN));
    assign w_issue      = (r_state == READ) && (r_remaining != {ADDR_W{1'b0}})
                          && w_room && !i_abort;
    assign w_issue_last = w_issue && (r_remaining == ADDR_W'(1));
    // The word returning in the abort cycle is dropped along with the FIFO.
    assign w_push       = r_inflight && !w_abort_hit;
    assign w_pop        = o_out_valid && i_out_ready;

    assign o_mem_address    = r_addr;
    assign o_mem_chipselect = w_issue;
    assign o_mem_write      = 1'b0;
    assign o_mem_byteenable = 4'hF;
    assign o_mem_clken      = 1'b1;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_out_valid      = !w_fifo_empty;
    assign o_out_data       = w_fifo_head[DATA_W-1:0];
    assign o_out_last       = w_fifo_head[DATA_W] && !w_fifo_empty;

    stream_reader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_flush (w_abort_hit),
        .i_push  (w_push),
        .i_data  ({r_inflight_last, i_mem_readdata}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_head),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    // Next-state decode of the transfer controller.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                // A zero-length request has nothing to read, so it goes
                // straight to the drain check and finishes a cycle later.
                if (i_start) begin
                    if (i_length == {ADDR_W{1'b0}}) begin
                        w_state_nxt = DRAIN;
                    end else begin
                        w_state_nxt = READ;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            READ: begin
                if (i_abort) begin
                    w_state_nxt = DONE;
`ifdef STREAM_READER_WRAP_EN
                end else begin
                    w_state_nxt = READ;
                end
`else
                end else if (w_issue_last) begin
                    w_state_nxt = DRAIN;
                end else begin
                    w_state_nxt = READ;
                end
`endif
            end
            DRAIN: begin
                if (i_abort) begin
                    w_state_nxt = DONE;
                end else if (!r_inflight && w_fifo_empty) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = DRAIN;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register with registered busy/done status.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= (w_state_nxt == DONE);
        end
    end

    // Address/remaining counters and the one-deep in-flight tracker.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_addr          <= {ADDR_W{1'b0}};
            r_remaining     <= {ADDR_W{1'b0}};
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
`ifdef STREAM_READER_WRAP_EN
            r_base          <= {ADDR_W{1'b0}};
            r_len           <= {ADDR_W{1'b0}};
`endif
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue_last;
            if ((r_state == IDLE) && i_start) begin
                r_addr      <= i_base_addr;
                r_remaining <= i_length;
`ifdef STREAM_READER_WRAP_EN
                r_base      <= i_base_addr;
                r_len       <= i_length;
`endif
            end else if (w_issue) begin
`ifdef STREAM_READER_WRAP_EN
                if (w_issue_last) begin
                    r_addr      <= r_base;
                    r_remaining <= r_len;
                end else begin
                    r_addr      <= r_addr + ADDR_W'(1);
                    r_remaining <= r_remaining - ADDR_W'(1);
                end
`else
                r_addr      <= r_addr + ADDR_W'(1);
                r_remaining <= r_remaining - ADDR_W'(1);
`endif
            end else begin
                r_addr      <= r_addr;
                r_remaining <= r_remaining;
            end
        end
    end

endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
module tb_onchip_mem_stream_reader;

    logic        clk          = 1'b0;
    logic        reset        = 1'b1;
    logic        start        = 1'b0;
    logic        abort        = 1'b0;
    logic        out_ready    = 1'b0;
    logic [16:0] base_addr    = 17'h0;
    logic [16:0] length       = 17'h0;
    logic [31:0] mem_readdata = 32'h0;
    logic        busy, done, mem_chipselect, mem_write, mem_clken;
    logic        out_valid, out_last;
    logic [16:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic [31:0] out_data;

    int          checks = 0;
    int          errors = 0;
    logic [16:0] addrq[$];
    int          icyc[$];
    logic [31:0] beatq[$];
    logic        lastq[$];
    int          done_cnt  = 0;
    int          cyc       = 0;
    int          stab_viol = 0;
    logic        stab_en   = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = 32'h0;

    onchip_mem_stream_reader dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_start          (start),
        .i_base_addr      (base_addr),
        .i_length         (length),
        .i_abort          (abort),
        .o_busy           (busy),
        .o_done           (done),
        .o_mem_address    (mem_address),
        .o_mem_chipselect (mem_chipselect),
        .o_mem_write      (mem_write),
        .o_mem_byteenable (mem_byteenable),
        .o_mem_clken      (mem_clken),
        .i_mem_readdata   (mem_readdata),
        .o_out_data       (out_data),
        .o_out_valid      (out_valid),
        .i_out_ready      (out_ready),
        .o_out_last       (out_last)
    );

    always #5 clk = ~clk;

    // RAM contents: word at address a is {8'hD0, 7'h00, a}.
    function automatic logic [31:0] ram_word(input logic [16:0] a);
        return {8'hD0, 7'h00, a};
    endfunction

    // RAM model: read latency one cycle.
    always @(posedge clk) begin
        if (mem_chipselect) mem_readdata <= ram_word(mem_address);
    end

    // Monitor: issued addresses, stream beats, done pulses, stall stability.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_chipselect) begin
                addrq.push_back(mem_address);
                icyc.push_back(cyc);
            end
            if (out_valid && out_ready) begin
                beatq.push_back(out_data);
                lastq.push_back(out_last);
            end
            if (done) done_cnt++;
            if (stab_en && prev_stall && (!out_valid || out_data !== prev_data)) stab_viol++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
        cyc++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [16:0] b, input logic [16:0] l);
        base_addr = b;
        length    = l;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic clear_mon();
        addrq.delete();
        icyc.delete();
        beatq.delete();
        lastq.delete();
        done_cnt = 0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < maxc) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
        end
        chk(tag, 64'(seen), 64'd1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin : main
        logic [31:0] exp1 [4];
        logic [16:0] exp4a [3];
        logic [31:0] exp4d [3];
        exp1  = '{32'hD0000010, 32'hD0000011, 32'hD0000012, 32'hD0000013};
        exp4a = '{17'h1FFFE, 17'h1FFFF, 17'h00000};
        exp4d = '{32'hD001FFFE, 32'hD001FFFF, 32'hD0000000};

        // Reset values
        #2;
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_done",  64'(done), 64'd0);
        chk("rst_addr",  64'(mem_address), 64'd0);
        chk("rst_cs",    64'(mem_chipselect), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_last",  64'(out_last), 64'd0);
        chk("tie_write", 64'(mem_write), 64'd0);
        chk("tie_be",    64'(mem_byteenable), 64'hF);
        chk("tie_clken", 64'(mem_clken), 64'd1);
        tick();
        tick();
        reset = 1'b0;
        tick();

`ifdef STREAM_READER_WRAP_EN
        // Circular buffer of 3 words, aborted after 9 issues
        clear_mon();
        out_ready = 1'b1;
        pulse_start(17'h40, 17'd3);
        repeat (9) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("wr_issues", 64'(addrq.size()), 64'd9);
        for (int i = 0; i < 9; i++) chk("wr_addr", 64'(addrq[i]), 64'(17'h40 + 17'(i % 3)));
        for (int i = 0; i < 6; i++) begin
            chk("wr_data", 64'(beatq[i]), 64'(32'hD0000040 + 32'(i % 3)));
            chk("wr_last", 64'(lastq[i]), 64'((i % 3) == 2));
        end
        repeat (4) tick();
        chk("wr_done_cnt", 64'(done_cnt), 64'd1);
        chk("wr_busy_end", 64'(busy), 64'd0);
`else
        // 1: four words, always ready
        clear_mon();
        out_ready = 1'b1;
        pulse_start(17'h10, 17'd4);
        wait_done("t1_done_seen", 40);
        tick();
        chk("t1_issues", 64'(addrq.size()), 64'd4);
        for (int i = 0; i < 4; i++) chk("t1_addr", 64'(addrq[i]), 64'(17'h10 + 17'(i)));
        chk("t1_consecutive", 64'(icyc[3] - icyc[0]), 64'd3);
        chk("t1_beats", 64'(beatq.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_data", 64'(beatq[i]), 64'(exp1[i]));
            chk("t1_last", 64'(lastq[i]), 64'(i == 3));
        end
        chk("t1_done_cnt", 64'(done_cnt), 64'd1);

        // 2: consumer stalled for 10 cycles, eight words
        clear_mon();
        stab_en   = 1'b1;
        out_ready = 1'b0;
        pulse_start(17'h10, 17'd8);
        repeat (9) tick();
        chk("t2_stall_issues", 64'(addrq.size()), 64'd4);
        chk("t2_stall_cs",     64'(mem_chipselect), 64'd0);
        chk("t2_stall_valid",  64'(out_valid), 64'd1);
        out_ready = 1'b1;
        wait_done("t2_done_seen", 60);
        tick();
        chk("t2_beats", 64'(beatq.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            chk("t2_data", 64'(beatq[i]), 64'(32'hD0000010 + 32'(i)));
            chk("t2_last", 64'(lastq[i]), 64'(i == 7));
        end
        chk("t2_stable", 64'(stab_viol), 64'd0);
        stab_en = 1'b0;

        // 3: zero length
        clear_mon();
        pulse_start(17'h55, 17'd0);
        @(negedge clk);
        chk("t3_c1_busy", 64'(busy), 64'd1);
        chk("t3_c1_done", 64'(done), 64'd0);
        @(negedge clk);
        chk("t3_c2_busy", 64'(busy), 64'd1);
        chk("t3_c2_done", 64'(done), 64'd1);
        @(negedge clk);
        chk("t3_c3_busy", 64'(busy), 64'd0);
        chk("t3_c3_done", 64'(done), 64'd0);
        tick();
        chk("t3_no_issue", 64'(addrq.size()), 64'd0);

        // 4: address wrap at the top of the address space
        clear_mon();
        pulse_start(17'h1FFFE, 17'd3);
        wait_done("t4_done_seen", 40);
        tick();
        chk("t4_issues", 64'(addrq.size()), 64'd3);
        chk("t4_beats", 64'(beatq.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            chk("t4_addr", 64'(addrq[i]), 64'(exp4a[i]));
            chk("t4_data", 64'(beatq[i]), 64'(exp4d[i]));
            chk("t4_last", 64'(lastq[i]), 64'(i == 2));
        end

        // 5: abort while stalled, then a fresh transfer
        clear_mon();
        out_ready = 1'b0;
        pulse_start(17'h100, 17'd100);
        tick();
        tick();
        abort = 1'b1;
        @(negedge clk);
        chk("t5_valid_pre", 64'(out_valid), 64'd1);
        chk("t5_cs_abort",  64'(mem_chipselect), 64'd0);
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("t5_valid_drop", 64'(out_valid), 64'd0);
        chk("t5_done",       64'(done), 64'd1);
        @(negedge clk);
        chk("t5_idle", 64'(busy), 64'd0);
        tick();
        out_ready = 1'b1;
        repeat (5) tick();
        chk("t5_no_beats", 64'(beatq.size()), 64'd0);
        chk("t5_issues",   64'(addrq.size()), 64'd2);
        chk("t5_done_cnt", 64'(done_cnt), 64'd1);
        clear_mon();
        pulse_start(17'h20, 17'd2);
        wait_done("t5_restart_done", 40);
        tick();
        chk("t5_re_beats", 64'(beatq.size()), 64'd2);
        chk("t5_re_d0", 64'(beatq[0]), 64'h00000000D0000020);
        chk("t5_re_d1", 64'(beatq[1]), 64'h00000000D0000021);
        chk("t5_re_last", 64'({lastq[0], lastq[1]}), 64'd1);

        // 6: reset in the middle of a transfer
        clear_mon();
        out_ready = 1'b1;
        pulse_start(17'h30, 17'd8);
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("t6_busy",  64'(busy), 64'd0);
        chk("t6_done",  64'(done), 64'd0);
        chk("t6_addr",  64'(mem_address), 64'd0);
        chk("t6_cs",    64'(mem_chipselect), 64'd0);
        chk("t6_valid", 64'(out_valid), 64'd0);
        chk("t6_last",  64'(out_last), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        repeat (10) tick();
        chk("t6_no_done", 64'(done_cnt), 64'd0);
        chk("t6_idle",    64'(busy), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
